cmlb_assoc: RTL
===============

// Module: cmlb_assoc
// PURPOSE
//  Parametrised set-associative code/data translation buffer, successor to the fixed 8-way fetch MLB.
//  Holds VA-tag -> translation entries, tagged with ASID and a global bit.
//  Uses true-LRU replacement and a post-reset init sweep.
//  Adds single-entry, per-ASID and full invalidation, plus stall-aware registered lookup.
//  Sits between fetch/AGU address generation and the page walker fill path.
// PARAMETERS
//  WAYS     8    associativity, power of 2, 2..16
//  SETS     256  sets, power of 2, 16..1024; SI=log2(SETS), WI=log2(WAYS)
//  VA_W     52   virtual address bits used for index+tag
//  IDX_LSB  14   lowest VA bit of set index (page-size granule)
//  ASID_W   24   address-space id width
//  DATA_W   64   translation payload width
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous, active-high reset
//  stall        in   1        freeze: hold lookup outputs, no LRU update
//  lkp_en       in   1        lookup request
//  lkp_va       in   VA_W     lookup address
//  lkp_asid     in   ASID_W   current address space
//  lkp_valid    out  1        lookup result valid (registered)
//  lkp_hit      out  1        hit
//  lkp_data     out  DATA_W   payload of hitting way, 0 on miss
//  fill_en      in   1        write new translation
//  fill_va/fill_asid/fill_global/fill_data  in  VA_W/ASID_W/1/DATA_W  fill entry
//  fill_ack     out  1        fill accepted this cycle (combinational)
//  inv_en       in   1        invalidate request
//  inv_mode     in   2        0=by VA+ASID, 1=all non-global of ASID, 2/3=all
//  inv_va, inv_asid  in  VA_W/ASID_W  invalidate match values
//  busy         out  1        INIT or FLUSH sweep active; requests ignored
// BEHAVIOUR
//  - Index = va[IDX_LSB+SI-1:IDX_LSB]; tag = va[VA_W-1:IDX_LSB+SI].
//  - Hit = valid & tag== & (asid== | global). Multi-hit cannot occur by construction; if it does, lowest way wins.
//  - States: INIT, IDLE, FLUSH. rst (any state, incl. mid-sweep) -> INIT, cnt=0.
//  - INIT: one set per cycle: clear valids, age[w]=w; after set SETS-1 -> IDLE. busy=1 for exactly SETS cycles.
//  - Reset outputs: lkp_valid=0, lkp_hit=0, lkp_data=0, fill_ack=0, busy=1.
//  - Lookup, IDLE only: lkp_en & ~stall at cycle N -> lkp_valid/hit/data at N+1.
//    lkp_en while busy -> lkp_valid=1, lkp_hit=0 at N+1. While stall=1, outputs hold their previous values.
//  - LRU: per-set WI-bit age per way, a permutation 0..WAYS-1.
//    Touched way -> WAYS-1; ways with age > its old age decrement by 1.
//    A lookup hit touches its way when ~stall.
//  - Fill (IDLE, ~inv_en): if entry with same tag and (same asid, or global) exists, overwrite that way.
//    Otherwise victim = lowest invalid way, else way with age 0. Write valid=1 and touch the way.
//    fill_ack=1 same cycle. Fill with inv_en same cycle -> invalidate wins, fill_ack=0, caller retries.
//  - Lookup + fill to same set, same cycle: lookup sees pre-fill contents.
//    Same-set LRU update order: hit touch first, then fill touch.
//  - inv_mode 0: single cycle, clears the matching entry (global entries included); no LRU change.
//  - inv_mode 1/2/3: -> FLUSH, sweep SETS cycles clearing matching valids, then IDLE; busy=1 throughout.
//    LRU ages are not reset.
//  - Requests while busy are dropped (fill_ack=0); lookups still return a miss.
// TESTING
//  1. rst 1 cycle -> busy=1 for SETS(256) cycles, then 0; lookup of any VA -> lkp_valid=1, hit=0.
//  2. Fill va=0x4000 asid=5 data=0xAB -> fill_ack=1; lookup asid=5 next cycle -> hit=1, data=0xAB; asid=6 -> hit=0.
//     Global fill va=0x8000: lookup with asid=6 -> hit=1.
//  3. Fill WAYS+1 distinct tags into set 1, touching only the first between fills.
//     Ninth fill evicts the second-filled way; the first still hits.
//  4. Simultaneous fill_en+inv_en -> fill_ack=0, invalidate applied.
//     Re-fill of an existing tag+asid with new data -> no extra way used, lookup returns new data.
//  5. inv_mode=1 asid=5 after mixed fills -> busy 256 cycles.
//     asid=5 non-global misses; asid=5 global and asid=7 entries still hit.
//  6. stall=1 with lkp_en over 3 cycles -> outputs frozen, ages unchanged.
//     rst mid-FLUSH -> INIT restarts, all entries miss afterwards.

Source files
------------

// File: rtl/cmlb_assoc.sv
// Set-associative code/data translation buffer: ASID/global tagged entries, true-LRU
// replacement, post-reset init sweep, single/per-ASID/full invalidation, registered lookup.
module cmlb_assoc #(
  parameter int unsigned WAYS    = 8,
  parameter int unsigned SETS    = 256,
  parameter int unsigned VA_W    = 52,
  parameter int unsigned IDX_LSB = 14,
  parameter int unsigned ASID_W  = 24,
  parameter int unsigned DATA_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              lkp_en,
  input  logic [VA_W-1:0]   lkp_va,
  input  logic [ASID_W-1:0] lkp_asid,
  output logic              lkp_valid,
  output logic              lkp_hit,
  output logic [DATA_W-1:0] lkp_data,
  input  logic              fill_en,
  input  logic [VA_W-1:0]   fill_va,
  input  logic [ASID_W-1:0] fill_asid,
  input  logic              fill_global,
  input  logic [DATA_W-1:0] fill_data,
  output logic              fill_ack,
  input  logic              inv_en,
  input  logic [1:0]        inv_mode,
  input  logic [VA_W-1:0]   inv_va,
  input  logic [ASID_W-1:0] inv_asid,
  output logic              busy
);

  localparam int unsigned SI    = $clog2(SETS);
  localparam int unsigned WI    = $clog2(WAYS);
  localparam int unsigned TAG_W = VA_W - IDX_LSB - SI;

  typedef logic [SI-1:0]              idx_t;
  typedef logic [WI-1:0]              way_t;
  typedef logic [TAG_W-1:0]           tag_t;
  typedef logic [WAYS-1:0][WI-1:0]    ages_t;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FLUSH} state_e;

  // Entry storage; valids and ages are initialised by the INIT sweep
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   glob_q  [SETS];
  tag_t              tag_q   [SETS][WAYS];
  logic [ASID_W-1:0] asid_q  [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  ages_t             age_q   [SETS];

  state_e            state_q;
  idx_t              cnt_q;
  logic [1:0]        flush_mode_q;
  logic [ASID_W-1:0] flush_asid_q;

  idx_t            lkp_idx, fill_idx, inv_idx;
  tag_t            lkp_tag, fill_tag, inv_tag;
  logic [WAYS-1:0] lkp_match, fill_match, inv_match, flush_clr;
  way_t            lkp_way, fill_way;
  logic            lkp_go, lkp_touch, fill_go;
  ages_t           ages_l, ages_f, ages_f_new;
  logic            unused_va;

  // Touched way becomes most recent; younger ways shift down to keep a permutation
  function automatic ages_t touch(input ages_t a, input way_t w);
    ages_t r;
    r = a;
    for (int i = 0; i < int'(WAYS); i++) begin
      if (a[i] > a[w]) r[i] = a[i] - WI'(1);
    end
    r[w] = WI'(WAYS - 1);
    return r;
  endfunction

  function automatic way_t first_one(input logic [WAYS-1:0] v);
    way_t r;
    r = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (v[i]) r = WI'(i);
    end
    return r;
  endfunction

  function automatic way_t oldest(input ages_t a);
    way_t r;
    r = '0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (a[i] == '0) r = WI'(i);
    end
    return r;
  endfunction

  assign lkp_idx   = lkp_va[IDX_LSB +: SI];
  assign lkp_tag   = lkp_va[IDX_LSB+SI +: TAG_W];
  assign fill_idx  = fill_va[IDX_LSB +: SI];
  assign fill_tag  = fill_va[IDX_LSB+SI +: TAG_W];
  assign inv_idx   = inv_va[IDX_LSB +: SI];
  assign inv_tag   = inv_va[IDX_LSB+SI +: TAG_W];
  assign unused_va = ^{lkp_va[IDX_LSB-1:0], fill_va[IDX_LSB-1:0], inv_va[IDX_LSB-1:0]};

  // Tag compare, victim selection and same-cycle LRU merge
  always_comb begin
    lkp_match  = '0;
    fill_match = '0;
    inv_match  = '0;
    flush_clr  = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      lkp_match[w]  = valid_q[lkp_idx][w] && (tag_q[lkp_idx][w] == lkp_tag) &&
                      ((asid_q[lkp_idx][w] == lkp_asid) || glob_q[lkp_idx][w]);
      fill_match[w] = valid_q[fill_idx][w] && (tag_q[fill_idx][w] == fill_tag) &&
                      ((asid_q[fill_idx][w] == fill_asid) || glob_q[fill_idx][w]);
      inv_match[w]  = valid_q[inv_idx][w] && (tag_q[inv_idx][w] == inv_tag) &&
                      ((asid_q[inv_idx][w] == inv_asid) || glob_q[inv_idx][w]);
      flush_clr[w]  = (flush_mode_q == 2'd1) ?
                      (!glob_q[cnt_q][w] && (asid_q[cnt_q][w] == flush_asid_q)) : 1'b1;
    end
    lkp_way   = first_one(lkp_match);
    lkp_go    = (state_q == ST_IDLE) && lkp_en && !stall;
    lkp_touch = lkp_go && (|lkp_match);
    ages_l    = lkp_touch ? touch(age_q[lkp_idx], lkp_way) : age_q[lkp_idx];
    ages_f    = (lkp_touch && (lkp_idx == fill_idx)) ? ages_l : age_q[fill_idx];
    if (|fill_match)               fill_way = first_one(fill_match);
    else if (!(&valid_q[fill_idx])) fill_way = first_one(~valid_q[fill_idx]);
    else                           fill_way = oldest(ages_f);
    ages_f_new = touch(ages_f, fill_way);
    fill_go    = (state_q == ST_IDLE) && fill_en && !inv_en;
  end

  assign fill_ack = fill_go;
  assign busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      flush_mode_q <= '0;
      flush_asid_q <= '0;
      lkp_valid    <= 1'b0;
      lkp_hit      <= 1'b0;
      lkp_data     <= '0;
    end else begin
      if (!stall) begin
        lkp_valid <= lkp_en;
        lkp_hit   <= lkp_touch;
        lkp_data  <= lkp_touch ? data_q[lkp_idx][lkp_way] : '0;
      end
      case (state_q)
        ST_INIT: begin
          valid_q[cnt_q] <= '0;
          for (int w = 0; w < int'(WAYS); w++) age_q[cnt_q][w] <= WI'(w);
          cnt_q <= cnt_q + SI'(1);
          if (cnt_q == SI'(SETS - 1)) state_q <= ST_IDLE;
        end
        ST_FLUSH: begin
          valid_q[cnt_q] <= valid_q[cnt_q] & ~flush_clr;
          cnt_q <= cnt_q + SI'(1);
          if (cnt_q == SI'(SETS - 1)) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (lkp_touch) age_q[lkp_idx] <= ages_l;
          if (inv_en) begin
            if (inv_mode == 2'd0) begin
              valid_q[inv_idx] <= valid_q[inv_idx] & ~inv_match;
            end else begin
              state_q      <= ST_FLUSH;
              cnt_q        <= '0;
              flush_mode_q <= inv_mode;
              flush_asid_q <= inv_asid;
            end
          end else if (fill_en) begin
            // Fill touch lands after the hit touch when both hit the same set
            valid_q[fill_idx][fill_way] <= 1'b1;
            glob_q[fill_idx][fill_way]  <= fill_global;
            tag_q[fill_idx][fill_way]   <= fill_tag;
            asid_q[fill_idx][fill_way]  <= fill_asid;
            data_q[fill_idx][fill_way]  <= fill_data;
            age_q[fill_idx]             <= ages_f_new;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule
